// File: rtl/hv_adc_pkg.sv
// ============================================================================
// Module      : hv_adc_pkg
// Description : Shared types and constants for the HV ADC capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hv_adc_pkg;

    localparam int HV_ADC_DW        = 10;
    localparam int HV_ADC_TO_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        EMIT = 2'd3
    } hv_adc_st_e;

endpackage

`default_nettype wire

// File: rtl/hv_sync_cell.sv
// ============================================================================
// Module      : hv_sync_cell
// Description : Parameterized-depth single-bit synchronizer, resets to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hv_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("hv_sync_cell: STAGES must be at least 2");
    end

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hv_adc_capture.sv
// ============================================================================
// Module      : hv_adc_capture
// Description : Syncs an async ADC ready strobe, averages 2^AVG_LOG2 samples
//               (when HV_ADC_AVG_EN is defined) and emits a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hv_adc_capture
    import hv_adc_pkg::*;
#(
    parameter int DW          = HV_ADC_DW,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 2,
    parameter int TO_CYCLES   = HV_ADC_TO_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_adc_en,
    input  logic          i_adc_ready,
    input  logic [DW-1:0] i_adc_data,
    input  logic          i_timeout_clr,
    output logic [DW-1:0] o_adc_data,
    output logic          o_adc_ready,
    output logic          o_adc_timeout
);

    if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("hv_adc_capture: AVG_LOG2 must be within 0..4");
    end
    if (TO_CYCLES < 2) begin : g_bad_to
        $error("hv_adc_capture: TO_CYCLES must be at least 2");
    end

    localparam int              c_to_w    = $clog2(TO_CYCLES);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TO_CYCLES - 1);

    hv_adc_st_e        r_state;
    logic              w_sync;
    logic              r_sync_d;
    logic              r_rise_q;
    logic              w_rise;
    logic              w_take;
    logic [DW-1:0]     r_data;
    logic [c_to_w-1:0] r_to_cnt;
    logic              w_win_done;
    logic [DW-1:0]     w_avg;

    hv_sync_cell #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ready (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_adc_ready),
        .o_q     (w_sync)
    );

    // The delayed copy lets an edge that lands during EMIT be taken in WAIT.
    assign w_rise = w_sync & ~r_sync_d;
    assign w_take = w_rise | r_rise_q;

`ifdef HV_ADC_AVG_EN
    localparam int                  c_avg_log2 = AVG_LOG2;
    localparam logic [c_avg_log2:0] c_cnt_one  = (c_avg_log2 + 1)'(1);
    localparam logic [c_avg_log2:0] c_win      = (c_avg_log2 + 1)'(1 << c_avg_log2);

    logic [DW+c_avg_log2-1:0] r_acc;
    logic [c_avg_log2:0]      r_cnt;
    logic [c_avg_log2:0]      w_cnt_nxt;

    assign w_cnt_nxt  = r_cnt + c_cnt_one;
    assign w_win_done = (w_cnt_nxt == c_win);
    assign w_avg      = r_acc[DW+c_avg_log2-1:c_avg_log2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!i_adc_en) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == CAPT) begin
            r_acc <= r_acc + (DW + c_avg_log2)'(r_data);
            r_cnt <= w_cnt_nxt;
        end else if (r_state == EMIT) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end
`else
    assign w_win_done = 1'b1;
    assign w_avg      = r_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_sync_d      <= 1'b0;
            r_rise_q      <= 1'b0;
            r_data        <= '0;
            r_to_cnt      <= '0;
            o_adc_data    <= '0;
            o_adc_ready   <= 1'b0;
            o_adc_timeout <= 1'b0;
        end else begin
            r_sync_d    <= w_sync;
            r_rise_q    <= w_rise;
            o_adc_ready <= 1'b0;
            if (i_timeout_clr) begin
                o_adc_timeout <= 1'b0;
            end
            if (!i_adc_en) begin
                r_state  <= IDLE;
                r_to_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_to_cnt <= '0;
                        r_state  <= WAIT;
                    end
                    WAIT: begin
                        if (w_take) begin
                            r_data   <= i_adc_data;
                            r_to_cnt <= '0;
                            r_state  <= CAPT;
                        end else if (r_to_cnt == c_to_last) begin
                            // Assigned after the clear so a coincident expiry wins.
                            r_to_cnt      <= '0;
                            o_adc_timeout <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    CAPT: begin
                        r_state <= w_win_done ? EMIT : WAIT;
                    end
                    EMIT: begin
                        o_adc_data  <= w_avg;
                        o_adc_ready <= 1'b1;
                        r_state     <= WAIT;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hv_adc_capture.sv
// ============================================================================
// Module      : tb_hv_adc_capture
// Description : Directed self-checking bench for hv_adc_capture (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hv_adc_capture;

    localparam int c_dw   = 10;
    localparam int c_sync = 2;
    localparam int c_to   = 40;
`ifdef HV_ADC_AVG_EN
    localparam int c_win     = 4;
    localparam int c_e_avg   = 101;  // (100+101+102+103)>>2
    localparam int c_e_trunc = 25;   // (10+20+30+41)=101, >>2
    localparam int c_e_held  = 10;   // (40+0+0+0)>>2
`else
    localparam int c_win     = 1;
    localparam int c_e_avg   = 103;
    localparam int c_e_trunc = 41;
    localparam int c_e_held  = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            adc_en;
    logic            adc_ready;
    logic [c_dw-1:0] adc_data;
    logic            timeout_clr;
    logic [c_dw-1:0] out_data;
    logic            out_ready;
    logic            out_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_pulse_cyc = -1;
    int bad_chg  = 0;
    logic [c_dw-1:0] last_data = '0;
    logic [c_dw-1:0] prev_data = '0;

    hv_adc_capture #(
        .DW          (c_dw),
        .SYNC_STAGES (c_sync),
        .AVG_LOG2    (2),
        .TO_CYCLES   (c_to)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_adc_en      (adc_en),
        .i_adc_ready   (adc_ready),
        .i_adc_data    (adc_data),
        .i_timeout_clr (timeout_clr),
        .o_adc_data    (out_data),
        .o_adc_ready   (out_ready),
        .o_adc_timeout (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampled 2 time units after each rising edge; cyc is the edge index.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (out_ready) begin
            pulses         = pulses + 1;
            last_data      = out_data;
            last_pulse_cyc = cyc;
        end else if (out_data !== prev_data) begin
            bad_chg = bad_chg + 1;
        end
        prev_data = out_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic conv(input logic [c_dw-1:0] d, input int hi, input int lo, output int t0);
        adc_data  = d;
        adc_ready = 1'b1;
        t0        = cyc + 1;
        repeat (hi) @(negedge clk);
        adc_ready = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        int p0;
        rst_n       = 1'b0;
        adc_en      = 1'b0;
        adc_ready   = 1'b1;
        adc_data    = '0;
        timeout_clr = 1'b0;

        // Reset with ready held high
        idle(3);
        check("rst_data", out_data, 0);
        check("rst_ready", out_ready, 0);
        check("rst_timeout", out_timeout, 0);
        rst_n = 1'b1;
        idle(6);
        adc_en = 1'b1;
        idle(10);
        check("rst_no_pulse", pulses, 0);
        adc_ready = 1'b0;
        idle(4);

        // Averaging window and latency
        p0 = pulses;
        conv(10'd100, 2, 4, t0);
        conv(10'd101, 2, 4, t0);
        conv(10'd102, 2, 4, t0);
        conv(10'd103, 2, 4, t0);
        idle(4);
        check("avg_pulses", pulses - p0, 4 / c_win);
        check("avg_data", last_data, c_e_avg);
        check("avg_latency", last_pulse_cyc, t0 + c_sync + 2);

        // Full scale
        p0 = pulses;
        for (int i = 0; i < 4; i++) conv(10'd1023, 2, 4, t0);
        idle(4);
        check("fs_pulses", pulses - p0, 4 / c_win);
        check("fs_data", last_data, 1023);

        // Truncating average
        p0 = pulses;
        conv(10'd10, 3, 5, t0);
        conv(10'd20, 1, 3, t0);
        conv(10'd30, 2, 4, t0);
        conv(10'd41, 2, 4, t0);
        idle(4);
        check("trunc_pulses", pulses - p0, 4 / c_win);
        check("trunc_data", last_data, c_e_trunc);

        // Long ready level counts as one sample
        p0 = pulses;
        conv(10'd40, 50, 4, t0);
        idle(2);
        check("held_one", pulses - p0, (c_win == 1) ? 1 : 0);
        for (int i = 0; i < 3; i++) conv(10'd0, 2, 4, t0);
        idle(4);
        check("held_pulses", pulses - p0, 4 / c_win);
        check("held_data", last_data, c_e_held);

        // Disable discards a partial window
        p0 = pulses;
        conv(10'd500, 2, 4, t0);
        conv(10'd500, 2, 4, t0);
        adc_en = 1'b0;
        idle(3);
        check("dis_partial", pulses - p0, (c_win == 1) ? 2 : 0);
        adc_en = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) conv(10'd8, 2, 4, t0);
        idle(4);
        check("dis_pulses", pulses - p0, (c_win == 1) ? 6 : 1);
        check("dis_data", last_data, 8);

        // Timeout: enable edge is e0, expiry at e0+c_to
        adc_en = 1'b0;
        idle(2);
        adc_en      = 1'b1;
        timeout_clr = 1'b1;
        idle(1);
        timeout_clr = 1'b0;
        idle(c_to - 1);
        check("to_before", out_timeout, 0);
        idle(1);
        check("to_set", out_timeout, 1);
        idle(c_to - 1);
        check("to_sticky", out_timeout, 1);
        timeout_clr = 1'b1;
        idle(1);
        timeout_clr = 1'b0;
        check("to_set_wins", out_timeout, 1);
        timeout_clr = 1'b1;
        idle(1);
        timeout_clr = 1'b0;
        check("to_clear", out_timeout, 0);

        check("data_hold", bad_chg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
